// File: rtl/siren_pkg.sv
// rtl/siren_pkg.sv - shared types, constants and lamp decode for the siren light-bar generator
// Contents:
//   mode_t        2-bit mode encoding (OFF, ALTERNATE, STROBE, CHASE)
//   STEPS_PER_FRAME / STEP_W  sequencer geometry
//   lamp_pattern  lamp vector for a given mode, step and lamp count (up to MAX_LAMPS)
package siren_pkg;

  localparam int STEPS_PER_FRAME = 8;
  localparam int STEP_W          = 3;
  localparam int MAX_LAMPS       = 16;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_ALT    = 2'd1,
    MODE_STROBE = 2'd2,
    MODE_CHASE  = 2'd3
  } mode_t;

  // Even lamp indices form the red group, odd indices the blue group.
  // Bits at or above n are always 0.
  function automatic logic [MAX_LAMPS-1:0] lamp_pattern(input mode_t m,
                                                        input logic [STEP_W-1:0] s,
                                                        input int n);
    logic [MAX_LAMPS-1:0] even_m;
    logic [MAX_LAMPS-1:0] odd_m;
    logic [MAX_LAMPS-1:0] r;
    even_m = '0;
    odd_m  = '0;
    r      = '0;
    for (int i = 0; i < MAX_LAMPS; i++) begin
      if (i < n) begin
        if ((i % 2) == 0) even_m[i] = 1'b1;
        else              odd_m[i]  = 1'b1;
      end
    end
    case (m)
      // s[2] selects the second half of the frame (steps 4..7)
      MODE_ALT:    r = s[2] ? odd_m : even_m;
      // strobe flashes on the even steps of each half
      MODE_STROBE: if (!s[0]) r = s[2] ? odd_m : even_m;
      // step never exceeds 7, so lamps 8+ stay dark when n > 8
      MODE_CHASE: begin
        for (int i = 0; i < MAX_LAMPS; i++) begin
          if (i < n && (int'(s) % n) == i) r[i] = 1'b1;
        end
      end
      default:     r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/siren_prescaler.sv
// rtl/siren_prescaler.sv - step-rate prescaler for the siren pattern sequencer
// Ports:
//   clk_in  in   1  clock
//   rst_n   in   1  asynchronous active-low reset
//   enb     in   1  count enable; counter holds while low
//   clear   in   1  force counter to 0 (frame restart), overrides counting
//   tick    out  1  high on the last count of each step while enabled
module siren_prescaler #(
  parameter int STEP_DIV = 15625000
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic enb,
  input  logic clear,
  output logic tick
);

  localparam int                CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] count;

  assign tick = enb && (count == LAST);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enb) begin
      count <= tick ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/siren_pattern_gen.sv
// rtl/siren_pattern_gen.sv - multi-lamp siren light-bar pattern generator
// Ports:
//   clk_in       in   1          clock
//   rst_n        in   1          asynchronous active-low reset
//   enb          in   1          run enable; low freezes sequencer and blanks lamps
//   mode         in   2          requested mode (0 OFF, 1 ALT, 2 STROBE, 3 CHASE)
//   lamp         out  NUM_LAMPS  registered lamp drive, 1 = lit
//   step         out  3          current step 0..7
//   frame_pulse  out  1          one-cycle pulse on step wrap 7->0
//   mode_active  out  2          mode currently applied
module siren_pattern_gen
  import siren_pkg::*;
#(
  parameter int STEP_DIV  = 15625000,
  parameter int NUM_LAMPS = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic                 enb,
  input  logic [1:0]           mode,
  output logic [NUM_LAMPS-1:0] lamp,
  output logic [STEP_W-1:0]    step,
  output logic                 frame_pulse,
  output logic [1:0]           mode_active
);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS_PER_FRAME - 1);

  mode_t                mode_q, mode_nxt, req;
  logic [STEP_W-1:0]    step_q, step_nxt;
  logic                 tick, clear, fp_nxt;
  logic [MAX_LAMPS-1:0] pat;
  logic [NUM_LAMPS-1:0] lamp_nxt;
  logic                 unused_pat;

  siren_prescaler #(.STEP_DIV(STEP_DIV)) u_prescaler (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .enb    (enb),
    .clear  (clear),
    .tick   (tick)
  );

  // Mode application: a safety blank acts at once, a start from OFF restarts
  // the frame, anything else waits for the frame boundary.
  always_comb begin
    req      = mode_t'(mode);
    mode_nxt = mode_q;
    step_nxt = step_q;
    clear    = 1'b0;
    fp_nxt   = tick && (step_q == LAST_STEP);
    if (enb) begin
      if (req == MODE_OFF && mode_q != MODE_OFF) begin
        mode_nxt = MODE_OFF;
        if (tick) step_nxt = step_q + STEP_W'(1);
      end else if (mode_q == MODE_OFF && req != MODE_OFF) begin
        mode_nxt = req;
        step_nxt = '0;
        clear    = 1'b1;
      end else if (tick) begin
        step_nxt = step_q + STEP_W'(1);
        if (step_q == LAST_STEP) mode_nxt = req;
      end
    end
  end

  always_comb begin
    pat      = lamp_pattern(mode_q, step_q, NUM_LAMPS);
    lamp_nxt = enb ? pat[NUM_LAMPS-1:0] : '0;
  end

  assign unused_pat = ^pat;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      step_q      <= '0;
      mode_q      <= MODE_OFF;
      lamp        <= '0;
      frame_pulse <= 1'b0;
    end else begin
      step_q      <= step_nxt;
      mode_q      <= mode_nxt;
      lamp        <= lamp_nxt;
      frame_pulse <= fp_nxt;
    end
  end

  assign step        = step_q;
  assign mode_active = mode_q;

endmodule

// File: tb/tb_siren_pattern_gen.sv
// tb/tb_siren_pattern_gen.sv - scoreboard testbench for siren_pattern_gen
module tb_siren_pattern_gen;
  import siren_pkg::*;

  logic       clk_in = 1'b0;
  logic       rst_n;
  logic       enb;
  logic [1:0] mode;
  logic [1:0] mode_aux;

  logic [3:0] lamp;
  logic [2:0] step;
  logic       frame_pulse;
  logic [1:0] mode_active;

  logic [1:0] lamp2;
  logic [2:0] step2;
  logic       fp2;
  logic [1:0] mode2;

  logic [8:0] lamp9;
  logic [2:0] step9;
  logic       fp9;
  logic [1:0] mode9;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  siren_pattern_gen #(.STEP_DIV(4), .NUM_LAMPS(4)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .enb(enb), .mode(mode),
    .lamp(lamp), .step(step), .frame_pulse(frame_pulse), .mode_active(mode_active)
  );

  siren_pattern_gen #(.STEP_DIV(2), .NUM_LAMPS(2)) dut2 (
    .clk_in(clk_in), .rst_n(rst_n), .enb(enb), .mode(mode_aux),
    .lamp(lamp2), .step(step2), .frame_pulse(fp2), .mode_active(mode2)
  );

  siren_pattern_gen #(.STEP_DIV(2), .NUM_LAMPS(9)) dut9 (
    .clk_in(clk_in), .rst_n(rst_n), .enb(enb), .mode(mode_aux),
    .lamp(lamp9), .step(step9), .frame_pulse(fp9), .mode_active(mode9)
  );

  typedef struct packed {
    logic [3:0] lamp;
    logic [2:0] step;
    logic [1:0] mode;
    logic       fp;
  } exp_t;

  exp_t sb_q[$];

  logic [3:0] alt_t [8] = '{4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b1010, 4'b1010, 4'b1010, 4'b1010};
  logic [3:0] str_t [8] = '{4'b0101, 4'b0000, 4'b0101, 4'b0000, 4'b1010, 4'b0000, 4'b1010, 4'b0000};
  logic [3:0] chs_t [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

  // Expectation for the outputs seen just after the next rising edge.
  task automatic expect_cyc(input logic [3:0] l, input logic [2:0] s, input mode_t m, input logic fp);
    exp_t e;
    e.lamp = l;
    e.step = s;
    e.mode = m;
    e.fp   = fp;
    sb_q.push_back(e);
    @(negedge clk_in);
  endtask

  // One 4-cycle step: the first cycle still shows the previous step's lamps.
  task automatic do_step(input logic [2:0] s, input mode_t m, input logic [3:0] l0,
                         input logic [3:0] l1, input logic fp);
    expect_cyc(l0, s, m, fp);
    repeat (3) expect_cyc(l1, s, m, 1'b0);
  endtask

  // Scoreboard monitor for the main instance.
  int sb_idx = 0;
  always @(posedge clk_in) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if ({lamp, step, mode_active, frame_pulse} !== e) begin
        errors++;
        $display("FAIL sb#%0d @%0t: got lamp=%b step=%0d mode=%0d fp=%b, want lamp=%b step=%0d mode=%0d fp=%b",
                 sb_idx, $time, lamp, step, mode_active, frame_pulse, e.lamp, e.step, e.mode, e.fp);
      end
      sb_idx++;
    end
  end

  // CHASE checks for the 2-lamp and 9-lamp instances: lamp[step % N] only.
  logic       aux_ok = 1'b0;
  logic       en_edge;
  logic [2:0] p2_step, p9_step;
  logic [1:0] p2_mode, p9_mode;
  logic [1:0] want2;
  logic [8:0] want9;
  always @(posedge clk_in) begin
    en_edge = enb;
    #1;
    if (rst_n && aux_ok) begin
      if (p2_mode == MODE_CHASE) begin
        want2 = en_edge ? (p2_step[0] ? 2'b10 : 2'b01) : 2'b00;
        checks++;
        if (lamp2 !== want2) begin
          errors++;
          $display("FAIL chase2 @%0t: got %b want %b", $time, lamp2, want2);
        end
      end
      if (p9_mode == MODE_CHASE) begin
        want9 = en_edge ? (9'd1 << p9_step) : 9'd0;
        checks++;
        if (lamp9 !== want9) begin
          errors++;
          $display("FAIL chase9 @%0t: got %b want %b", $time, lamp9, want9);
        end
      end
    end
    p2_step = step2;
    p2_mode = mode2;
    p9_step = step9;
    p9_mode = mode9;
    aux_ok  = rst_n;
  end

  initial begin
    rst_n    = 1'b0;
    enb      = 1'b0;
    mode     = MODE_OFF;
    mode_aux = MODE_CHASE;
    @(negedge clk_in);
    repeat (2) expect_cyc(4'b0000, 3'd0, MODE_OFF, 1'b0);

    // Start ALT from OFF: frame restarts, lamps follow one cycle later
    rst_n = 1'b1;
    enb   = 1'b1;
    mode  = MODE_ALT;
    expect_cyc(4'b0000, 3'd0, MODE_ALT, 1'b0);
    repeat (3) expect_cyc(alt_t[0], 3'd0, MODE_ALT, 1'b0);
    for (int s = 1; s < 8; s++) begin
      if (s == 3) begin
        // enb dropped mid-step 3: lamps blank, step and prescaler hold
        expect_cyc(alt_t[2], 3'd3, MODE_ALT, 1'b0);
        expect_cyc(alt_t[3], 3'd3, MODE_ALT, 1'b0);
        enb = 1'b0;
        repeat (10) expect_cyc(4'b0000, 3'd3, MODE_ALT, 1'b0);
        enb = 1'b1;
        repeat (2) expect_cyc(alt_t[3], 3'd3, MODE_ALT, 1'b0);
      end else begin
        do_step(3'(s), MODE_ALT, alt_t[s-1], alt_t[s], 1'b0);
      end
    end

    // Second ALT frame; CHASE requested at step 2 waits for the boundary
    do_step(3'd0, MODE_ALT, alt_t[7], alt_t[0], 1'b1);
    do_step(3'd1, MODE_ALT, alt_t[0], alt_t[1], 1'b0);
    mode = MODE_CHASE;
    for (int s = 2; s < 8; s++) do_step(3'(s), MODE_ALT, alt_t[s-1], alt_t[s], 1'b0);

    // CHASE frame
    do_step(3'd0, MODE_CHASE, alt_t[7], chs_t[0], 1'b1);
    for (int s = 1; s < 8; s++) do_step(3'(s), MODE_CHASE, chs_t[s-1], chs_t[s], 1'b0);

    // STROBE requested at step 1 then withdrawn at step 3: never applied
    do_step(3'd0, MODE_CHASE, chs_t[7], chs_t[0], 1'b1);
    mode = MODE_STROBE;
    for (int s = 1; s < 3; s++) do_step(3'(s), MODE_CHASE, chs_t[s-1], chs_t[s], 1'b0);
    mode = MODE_CHASE;
    for (int s = 3; s < 5; s++) do_step(3'(s), MODE_CHASE, chs_t[s-1], chs_t[s], 1'b0);

    // OFF at step 5 blanks immediately, sequencer keeps stepping
    expect_cyc(chs_t[4], 3'd5, MODE_CHASE, 1'b0);
    mode = MODE_OFF;
    expect_cyc(chs_t[5], 3'd5, MODE_OFF, 1'b0);
    repeat (2) expect_cyc(4'b0000, 3'd5, MODE_OFF, 1'b0);
    expect_cyc(4'b0000, 3'd6, MODE_OFF, 1'b0);

    // STROBE from OFF restarts the frame at step 0
    mode = MODE_STROBE;
    expect_cyc(4'b0000, 3'd0, MODE_STROBE, 1'b0);
    repeat (3) expect_cyc(str_t[0], 3'd0, MODE_STROBE, 1'b0);
    for (int s = 1; s < 8; s++) do_step(3'(s), MODE_STROBE, str_t[s-1], str_t[s], 1'b0);
    do_step(3'd0, MODE_STROBE, str_t[7], str_t[0], 1'b1);
    expect_cyc(str_t[0], 3'd1, MODE_STROBE, 1'b0);

    // Asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({lamp, step, frame_pulse, mode_active, lamp2, lamp9} !== '0) begin
      errors++;
      $display("FAIL async_rst: got lamp=%b step=%0d fp=%b mode=%0d lamp2=%b lamp9=%b, want all 0",
               lamp, step, frame_pulse, mode_active, lamp2, lamp9);
    end
    expect_cyc(4'b0000, 3'd0, MODE_OFF, 1'b0);
    rst_n = 1'b1;
    expect_cyc(4'b0000, 3'd0, MODE_STROBE, 1'b0);
    repeat (3) expect_cyc(str_t[0], 3'd0, MODE_STROBE, 1'b0);
    do_step(3'd1, MODE_STROBE, str_t[0], str_t[1], 1'b0);

    @(negedge clk_in);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d entries left, want 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
